hct_down_counter: RTL
=====================

// Module: hct_down_counter
// PURPOSE
// - Fully synchronous, parallel-loadable, cascadable binary DOWN counter with optional auto-reload.
// - Counterpart of the team's up-counter parts: it consumes a preset value and counts it out
//   to a terminal-count (borrow) pulse instead of counting up to carry.
// - Used as a programmable divide-by-N and loop/delay counter in the CPU control path.
// - Built as a chain of 4-bit slices with lookahead enable. HCT-style timing applies.
// PARAMETERS
// - SLICES       default 2  number of 4-bit slices; counter width W = 4*SLICES.
// - AUTO_RELOAD  default 0  1 = on an enabled count at zero, load D instead of wrapping to all-ones.
// PORTS
// - CP   input   1  clock; all state changes on posedge.
// - MR   input   1  master reset; synchronous, active-high.
// - CEP  input   1  count enable (parallel).
// - CET  input   1  count enable (trickle / borrow-in); also gates TC.
// - _PE  input   1  parallel load enable, active low.
// - D    input   W  parallel preset / reload value.
// - Q    output  W  current count.
// - TC   output  1  terminal count (borrow-out): (Q == 0) & CET; combinational.
// BEHAVIOUR
// - Priority at posedge CP: MR > ~_PE > (CEP & CET) > hold.
// - MR = 1: Q <= 0, regardless of _PE, CEP or CET.
//   - After reset, TC follows CET (Q == 0).
// - ~_PE: Q <= D. The load ignores CEP and CET.
// - CEP & CET, Q != 0: Q <= Q - 1.
// - CEP & CET, Q == 0:
//   - AUTO_RELOAD = 0: Q <= {W{1'b1}} (modular wrap).
//   - AUTO_RELOAD = 1: Q <= D. With D = N-1, TC is asserted for one cycle in every N (divide-by-N).
//   - D == 0 in reload mode: Q stays 0 and TC stays high while CET is high.
// - Otherwise: hold.
// - Latency: Q updates 1 clock after the qualifying edge. TC has no register stage.
// - Cascade: slice k is enabled with CET_k = CET & TC_0 & ... & TC_(k-1) (lookahead, not ripple).
//   - Every slice sees the same CEP, _PE and MR.
//   - Upper slices decrement only when all lower slices are at 0.
// - Reload at zero applies to the whole W-bit word:
//   - Reload is decided by the chain-level TC, not per slice.
//   - A slice must not reload alone when only that slice is at 0.
// - Reset or load in the middle of a count sequence takes effect on that edge.
//   - No count from the same edge is also applied.
// - MR and _PE asserted together: MR wins, Q = 0.
// - Timing (specify): CP->Q 20 ns, CP->TC 25 ns, CET->TC 14 ns.
// - Initial reg value is 0, matching the reset state.
// STRUCTURE
// - Shared package/include `hct_timing`: tPD constants for CP->Q, CP->TC and CET->TC.
//   - The up-counter uses the same constants.
// - Sub-module hct_down_slice4: 4-bit down counter with a D-select input driven by the top level.
//   - Slice ports: CP, MR, CEP, CET, _PE, D[3:0], RELOAD, Q[3:0], TC.
//   - RELOAD = the top-level chain-zero condition when AUTO_RELOAD = 1.
// - Top level: generate loop over SLICES, lookahead CET chain, chain TC.
// TESTING
// - Reset: load 8'hA5, then MR = 1 for one clock with _PE = 0 and CEP = CET = 1
//   -> Q = 8'h00 and TC = 1 on the next cycle.
// - Load/count: D = 8'h03, _PE pulse, then CEP = CET = 1
//   -> Q = 03, 02, 01, 00, FF.
//   - TC is high only while Q = 00.
// - Slice borrow: load 8'h10, count once -> Q = 8'h0F.
//   - The upper slice decrements only on the edge where the lower slice is 0.
// - Enable gating: Q = 8'h05.
//   - CEP = 0, CET = 1 for 3 clocks -> Q holds at 05.
//   - Load 00, set CET = 0 -> TC = 0 and Q holds 00.
//   - Raise CET -> TC = 1 within 14 ns.
// - Auto-reload (AUTO_RELOAD = 1): D = 8'h04, count continuously
//   -> Q sequence 04, 03, 02, 01, 00, 04, ...
//   - TC is high for 1 clock in every 5.
// - Reload with D = 0: Q stays 00 and TC stays at 1.

Source files
------------

// File: rtl/hct_down_counter_pkg.sv
// Shared constants for the HCT counter family: slice width and the datasheet
// propagation delays that the up- and down-counters both quote.
package hct_down_counter_pkg;

    localparam int SLICE_W = 4;

    // Datasheet propagation delays in ns; reference values, not modelled in RTL.
    localparam int T_CP_Q_NS   = 20;
    localparam int T_CP_TC_NS  = 25;
    localparam int T_CET_TC_NS = 14;

endpackage

// File: rtl/hct_down_counter_if.sv
// Control/data bundle of the down counter: enables and preset in, count and
// terminal-count out. CP and MR stay plain ports on the counter.
interface hct_down_counter_if #(
    parameter int W = 8
);
    logic         CEP;
    logic         CET;
    logic         _PE;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic         TC;

    modport master (
        output CEP, CET, _PE, D,
        input  Q, TC
    );

    modport slave (
        input  CEP, CET, _PE, D,
        output Q, TC
    );
endinterface

// File: rtl/hct_down_slice4.sv
// One 4-bit down-counter slice. RELOAD replaces the decrement with a load of D
// and is driven by the chain-level zero detect, never by the slice itself.
module hct_down_slice4
    import hct_down_counter_pkg::*;
(
    input  logic               CP,
    input  logic               MR,
    input  logic               CEP,
    input  logic               CET,
    input  logic               _PE,
    input  logic [SLICE_W-1:0] D,
    input  logic               RELOAD,
    output logic [SLICE_W-1:0] Q,
    output logic               TC
);

    logic [SLICE_W-1:0] q_q;
    logic [SLICE_W-1:0] q_d;

    // Decrement from 0 wraps to all-ones naturally when RELOAD is low.
    always_comb begin
        q_d = q_q;
        if (!_PE) begin
            q_d = D;
        end else if (CEP && CET) begin
            if (RELOAD) begin
                q_d = D;
            end else begin
                q_d = q_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q  = q_q;
    assign TC = (q_q == '0) && CET;

endmodule

// File: rtl/hct_down_counter.sv
// Cascadable down counter built from 4-bit slices with a lookahead trickle
// enable; optional whole-word auto-reload turns it into a divide-by-N.
module hct_down_counter
    import hct_down_counter_pkg::*;
#(
    parameter int SLICES      = 2,
    parameter int AUTO_RELOAD = 0
) (
    input  logic              CP,
    input  logic              MR,
    hct_down_counter_if.slave bus
);

    localparam int W = SLICE_W * SLICES;

    logic [W-1:0]      q_all;
    logic [SLICES-1:0] zero;
    logic [SLICES-1:0] cet;
    logic [SLICES-1:0] tc;
    logic              chain_zero;
    logic              reload;

    assign chain_zero = (q_all == '0);
    assign reload     = (AUTO_RELOAD != 0) && chain_zero;

    for (genvar k = 0; k < SLICES; k++) begin : g_slice
        assign zero[k] = (q_all[k*SLICE_W +: SLICE_W] == '0);

        // Lookahead: slice k sees CET only when every lower slice sits at 0.
        if (k == 0) begin : g_first
            assign cet[k] = bus.CET;
        end else begin : g_upper
            assign cet[k] = bus.CET && (&zero[k-1:0]);
        end

        hct_down_slice4 u_slice (
            .CP     (CP),
            .MR     (MR),
            .CEP    (bus.CEP),
            .CET    (cet[k]),
            ._PE    (bus._PE),
            .D      (bus.D[k*SLICE_W +: SLICE_W]),
            .RELOAD (reload),
            .Q      (q_all[k*SLICE_W +: SLICE_W]),
            .TC     (tc[k])
        );
    end

    assign bus.Q  = q_all;
    assign bus.TC = &tc;

endmodule
